// File: rtl/mac_dot8_sequencer.sv
// Sequences one 8:1 mux-input MAC slice through an 8-term dot product,
// feeding the running accumulator back as the MAC C operand each step.
module mac_dot8_sequencer #(
    parameter int A_width   = 8,
    parameter int B_width   = 8,
    parameter int SUM_width = 22
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [A_width*8-1:0]   in_A,
    input  logic [B_width*8-1:0]   in_B,
    input  logic [SUM_width-1:0]   in_C,
    input  logic                   in_TC,
    output logic [2:0]             mac_select,
    output logic [A_width*8-1:0]   mac_A,
    output logic [B_width-1:0]     mac_B,
    output logic [SUM_width-1:0]   mac_C,
    output logic                   mac_TC,
    input  logic [SUM_width-1:0]   mac_sum,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SUM_width-1:0]   out_sum
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                 state;
    logic [2:0]             cnt;
    logic [SUM_width-1:0]   acc;
    logic [A_width*8-1:0]   a_cap;
    logic [B_width*8-1:0]   b_cap;
    logic                   tc_cap;

    // Captured operands are cleared by reset so the MAC sees all-zero inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            acc       <= '0;
            a_cap     <= '0;
            b_cap     <= '0;
            tc_cap    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_cap    <= in_A;
                        b_cap    <= in_B;
                        tc_cap   <= in_TC;
                        acc      <= in_C;
                        cnt      <= 3'd0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= mac_sum;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Lane select and coefficient are only driven while stepping.
    always_comb begin
        mac_select = 3'd0;
        mac_B      = '0;
        if (state == RUN) begin
            mac_select = cnt;
            mac_B      = b_cap[int'(cnt)*B_width +: B_width];
        end
    end

    assign mac_A   = a_cap;
    assign mac_C   = acc;
    assign mac_TC  = tc_cap;
    assign out_sum = acc;

endmodule

// File: tb/tb_mac_dot8_sequencer.sv
// Self-checking bench for mac_dot8_sequencer with a behavioural MAC slice
// and a job-level reference model compared every cycle.
module tb_mac_dot8_sequencer;

    localparam int AW = 8;
    localparam int BW = 8;
    localparam int SW = 22;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [AW*8-1:0] in_A;
    logic [BW*8-1:0] in_B;
    logic [SW-1:0]   in_C;
    logic            in_TC;
    logic [2:0]      mac_select;
    logic [AW*8-1:0] mac_A;
    logic [BW-1:0]   mac_B;
    logic [SW-1:0]   mac_C;
    logic            mac_TC;
    logic [SW-1:0]   mac_sum;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_sum;

    always #5 clk = ~clk;

    mac_dot8_sequencer #(.A_width(AW), .B_width(BW), .SUM_width(SW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .in_C(in_C), .in_TC(in_TC),
        .mac_select(mac_select), .mac_A(mac_A), .mac_B(mac_B), .mac_C(mac_C),
        .mac_TC(mac_TC), .mac_sum(mac_sum), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum)
    );

    function automatic int prod(input logic [7:0] a, input logic [7:0] b, input logic tc);
        if (tc) return int'($signed(a)) * int'($signed(b));
        return int'(a) * int'(b);
    endfunction

    // MAC slice: SUM = C + A[select]*B, wrapping at SW bits
    function automatic logic [SW-1:0] mac_fn(input logic [7:0] a, input logic [7:0] b,
                                             input logic [SW-1:0] c, input logic tc);
        int p;
        p = prod(a, b, tc);
        return c + p[SW-1:0];
    endfunction

    always_comb mac_sum = mac_fn(mac_A[int'(mac_select)*8 +: 8], mac_B, mac_C, mac_TC);

    // C plus the first n products of the job, modulo 2^SW
    function automatic logic [SW-1:0] partial(input logic [63:0] a, input logic [63:0] b,
                                              input logic [SW-1:0] c, input logic tc, input int n);
        longint t;
        t = longint'(c);
        for (int k = 0; k < n; k++) t += longint'(prod(a[k*8 +: 8], b[k*8 +: 8], tc));
        return t[SW-1:0];
    endfunction

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    bit            m_init = 0;
    bit            m_active = 0;
    int            m_acc_cyc = 0;
    logic [63:0]   m_A = '0, m_B = '0;
    logic [SW-1:0] m_C = '0, m_res = '0, m_last = '0;
    logic          m_tc = 1'b0;

    int            acc_q[$];
    logic [SW-1:0] res_q[$];
    int            resc_q[$];

    always @(negedge clk) begin
        int d;
        bit run, done;
        d = cyc - m_acc_cyc;
        run = m_active && d >= 1 && d <= 8;
        done = m_active && d >= 9;
        if (m_init) begin
            chk("in_ready", in_ready, !m_active);
            chk("out_valid", out_valid, done);
            if (done) chk("out_sum", out_sum, m_res);
            chk("mac_select", mac_select, run ? 3'(d - 1) : 3'd0);
            chk("mac_B", mac_B, run ? m_B[(d-1)*8 +: 8] : 8'd0);
            chk("mac_C", mac_C, run ? partial(m_A, m_B, m_C, m_tc, d - 1) :
                                (done ? m_res : m_last));
            chk("mac_A", mac_A, m_A);
            chk("mac_TC", mac_TC, m_tc);
        end
        if (!rst) begin
            if (in_valid && in_ready) acc_q.push_back(cyc);
            if (out_valid && out_ready) begin
                res_q.push_back(out_sum);
                resc_q.push_back(cyc);
            end
        end
        if (rst) begin
            m_init = 1;
            m_active = 0;
            m_A = '0; m_B = '0; m_tc = 1'b0; m_last = '0;
        end else if (m_init) begin
            if (!m_active && in_valid) begin
                m_active = 1;
                m_acc_cyc = cyc;
                m_A = in_A; m_B = in_B; m_C = in_C; m_tc = in_TC;
                m_res = partial(in_A, in_B, in_C, in_TC, 8);
            end else if (done && out_ready) begin
                m_active = 0;
                m_last = m_res;
            end
        end
    end

    task automatic give_job(input logic [63:0] a, input logic [63:0] b, input logic [SW-1:0] c,
                            input logic tc, input bit hold);
        int n0;
        n0 = acc_q.size();
        in_A = a; in_B = b; in_C = c; in_TC = tc; in_valid = 1'b1;
        for (int i = 0; i < 60 && acc_q.size() == n0; i++) @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
        if (acc_q.size() == n0) timeout("accept");
    endtask

    task automatic get_result(output logic [SW-1:0] s, output int c);
        s = 'x;
        c = -1000;
        for (int i = 0; i < 60 && res_q.size() == 0; i++) @(negedge clk);
        if (res_q.size() == 0) timeout("result");
        else begin
            s = res_q.pop_front();
            c = resc_q.pop_front();
        end
    endtask

    function automatic int pop_acc();
        if (acc_q.size() == 0) return -1000;
        return acc_q.pop_front();
    endfunction

    localparam logic [63:0] J1_A = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [63:0] J1_B = {8{8'd3}};
    localparam logic [63:0] J2_A = {8{8'hFF}};
    localparam logic [63:0] J2_B = {8{8'h02}};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SW-1:0] s;
        int ca, ca2, cr;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_A = J1_A; in_B = J1_B; in_C = 22'd10; in_TC = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sum", out_sum, 22'd0);
        chk("rst_mac_C", mac_C, 22'd0);
        chk("rst_no_accept", acc_q.size(), 0);
        @(posedge clk); #1;

        // unsigned job with latency
        give_job(J1_A, J1_B, 22'd10, 1'b0, 0);
        ca = pop_acc();
        get_result(s, cr);
        chk("t1_sum", s, 22'h000076);
        chk("t1_latency", cr - ca, 9);

        // signed job
        give_job(J2_A, J2_B, 22'd0, 1'b1, 0);
        ca = pop_acc();
        get_result(s, cr);
        chk("t2_sum", s, 22'h3FFFF0);

        // modular wrap
        give_job({8{8'hFF}}, {8{8'hFF}}, 22'h3FFFFF, 1'b0, 0);
        ca = pop_acc();
        get_result(s, cr);
        chk("t3_sum", s, 22'h07F007);

        // backpressure in DONE with ignored in_valid pulses
        out_ready = 1'b0;
        give_job(J1_A, J1_B, 22'd10, 1'b0, 0);
        ca = pop_acc();
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        if (!out_valid) timeout("t4_out_valid");
        @(posedge clk); #1;
        in_A = J2_A; in_B = J2_B; in_C = 22'd0; in_TC = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", out_valid, 1'b1);
            chk("t4_hold_sum", out_sum, 22'd118);
            chk("t4_in_ready", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        get_result(s, cr);
        chk("t4_sum", s, 22'd118);
        chk("t4_no_accept", acc_q.size(), 0);
        @(negedge clk);
        chk("t4_idle_ready", in_ready, 1'b1);
        chk("t4_idle_valid", out_valid, 1'b0);
        @(posedge clk); #1;

        // reset during RUN step 4
        give_job(J2_A, J2_B, 22'd5, 1'b1, 0);
        ca = pop_acc();
        repeat (4) @(posedge clk);
        #1;
        chk("t5_step4", mac_select, 3'd4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_in_ready", in_ready, 1'b1);
        chk("t5_out_valid", out_valid, 1'b0);
        chk("t5_mac_A", mac_A, 64'd0);
        chk("t5_mac_B", mac_B, 8'd0);
        chk("t5_mac_C", mac_C, 22'd0);
        chk("t5_mac_TC", mac_TC, 1'b0);
        chk("t5_mac_select", mac_select, 3'd0);
        @(posedge clk); #1;
        give_job(J1_A, J1_B, 22'd10, 1'b0, 0);
        ca = pop_acc();
        get_result(s, cr);
        chk("t5_sum", s, 22'd118);
        chk("t5_no_partial", res_q.size(), 0);

        // back-to-back jobs with in_valid held high
        give_job(J1_A, J1_B, 22'd10, 1'b0, 1);
        ca = pop_acc();
        give_job(J2_A, J2_B, 22'd0, 1'b1, 0);
        ca2 = pop_acc();
        chk("t6_period", ca2 - ca, 10);
        get_result(s, cr);
        chk("t6_sum1", s, 22'd118);
        get_result(s, cr);
        chk("t6_sum2", s, 22'h3FFFF0);
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
